// File: rtl/call_request_latch.sv
// Purpose: synchronise and debounce three call buttons and latch one pending call per floor.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES from a clean raw edge to the registered request update.
// Backpressure: none; calls are held until the car serves the floor (door open at that floor).
// Optional build macro CALL_CANCEL_EN: a press held for LONG_PRESS cycles cancels that floor's call.
module call_request_latch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_PRESS      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] button,
    input  logic [2:0] floor,
    input  logic       door,
    output logic [2:0] request,
    output logic [2:0] led,
    output logic       req_any,
    output logic       new_req
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // Counter is sized to hold DEBOUNCE_CYCLES exactly, so it saturates instead of wrapping.
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    // Elaboration-time guard against parameter values the debouncer cannot honour.
    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS < 1) begin : g_param_check
        $error("call_request_latch: DEBOUNCE_CYCLES and LONG_PRESS must be >= 1");
    end

    logic [2:0]    sync1_q, sync2_q;
    db_state_e     state_q [3];
    db_state_e     state_d [3];
    logic [CW-1:0] cnt_q   [3];
    logic [CW-1:0] cnt_d   [3];
    logic [2:0]    press;
    logic [2:0]    cancel;
    logic [2:0]    clr;
    logic [2:0]    request_q, request_d;
    logic          req_any_q, new_req_q;

    // Two-flop synchroniser per raw button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state and counter registers, one set per button.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Debounce next state: a new level must persist DEBOUNCE_CYCLES more cycles after first seen.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            press[i]   = 1'b0;
            case (state_q[i])
                RELEASED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        press[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

`ifdef CALL_CANCEL_EN
    localparam int            HW        = $clog2(LONG_PRESS + 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS - 1);

    logic [HW-1:0] hold_q [3];
    logic [HW-1:0] hold_d [3];

    // Hold counters survive a release bounce so the cancel fires only once per debounced press.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hold_d[i] = hold_q[i];
            cancel[i] = (state_q[i] == PRESSED) && (hold_q[i] == HOLD_LAST);
            if (state_q[i] == RELEASED || state_q[i] == PRESS_WAIT) begin
                hold_d[i] = '0;
            end else if (state_q[i] == PRESSED && hold_q[i] != HOLD_MAX) begin
                hold_d[i] = hold_q[i] + HOLD_ONE;
            end
        end
    end

    // Long-press hold counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                hold_q[i] <= '0;
            end else begin
                hold_q[i] <= hold_d[i];
            end
        end
    end
`else
    assign cancel = '0;
`endif

    // Call latch: serving the floor beats cancel, cancel beats a new press.
    always_comb begin
        clr       = floor & {3{door}};
        request_d = ~clr & ~cancel & (press | request_q);
    end

    // Registered outputs; summary flags are computed from the next request so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            request_q <= '0;
            req_any_q <= 1'b0;
            new_req_q <= 1'b0;
        end else begin
            request_q <= request_d;
            req_any_q <= |request_d;
            new_req_q <= |(request_d & ~request_q);
        end
    end

    assign request = request_q;
    assign led     = request_q;
    assign req_any = req_any_q;
    assign new_req = new_req_q;

endmodule

// File: tb/tb_call_request_latch.sv
module tb_call_request_latch;

    localparam int DB = 4;
    localparam int LP = 20;

    logic       clk;
    logic       reset_r;
    logic [2:0] button_r;
    logic [2:0] floor_r;
    logic       door_r;
    logic [2:0] request_w;
    logic [2:0] led_w;
    logic       req_any_w;
    logic       new_req_w;

    int errors;
    int checks;

    call_request_latch #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS(LP)) dut (
        .clk     (clk),
        .reset   (reset_r),
        .button  (button_r),
        .floor   (floor_r),
        .door    (door_r),
        .request (request_w),
        .led     (led_w),
        .req_any (req_any_w),
        .new_req (new_req_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each button's debounced level flips once its synchronised value has
    // disagreed with that level on DB+1 consecutive clock edges.
    bit [2:0] m_s1, m_s2, m_lvl, m_req;
    bit       m_new;
    int       m_run  [3];
    int       m_hold [3];

    task automatic model_update();
        bit [2:0] press;
        bit [2:0] cancel;
        bit [2:0] clr;
        bit [2:0] nxt;
        press  = '0;
        cancel = '0;
        if (reset_r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_req = '0; m_new = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
`ifdef CALL_CANCEL_EN
                if (m_lvl[i] && m_run[i] == 0 && m_hold[i] == LP - 1) cancel[i] = 1'b1;
                if (!m_lvl[i]) m_hold[i] = 0;
                else if (m_run[i] == 0 && m_hold[i] < LP) m_hold[i]++;
`endif
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) press[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            clr   = floor_r & {3{door_r}};
            nxt   = ~clr & ~cancel & (press | m_req);
            m_new = |(nxt & ~m_req);
            m_req = nxt;
            m_s2  = m_s1;
            m_s1  = button_r;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [7:0] pk(input logic [2:0] r, input logic n);
        return {r, r, |r, n};
    endfunction

    task automatic check(input string name, input logic [2:0] r, input logic n);
        logic [7:0] act;
        logic [7:0] exp;
        act = {request_w, led_w, req_any_w, new_req_w};
        exp = pk(r, n);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got {req,led,any,new}=%b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_r  = 1'b1;
        button_r = '0;
        floor_r  = '0;
        door_r   = 1'b0;
        repeat (3) tick();
        check("reset_state", 3'b000, 1'b0);
        reset_r = 1'b0;
    endtask

    typedef struct {
        bit       rst;
        bit [2:0] btn;
        bit [2:0] flr;
        bit       dr;
        bit [2:0] exp_req;
        bit       exp_new;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [2:0] er;
        int         pat [5];
        errors   = 0;
        checks   = 0;
        reset_r  = 1'b1;
        button_r = '0;
        floor_r  = '0;
        door_r   = 1'b0;
        @(negedge clk);

        // Buttons held through reset, then served at one floor, two floors and a non-one-hot floor.
        for (int k = 0; k < 3; k++) vecs[k] = '{1'b1, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0};
        for (int k = 3; k < 9; k++) vecs[k] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0};
        vecs[9]  = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b111, 1'b1};
        vecs[10] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b111, 1'b0};
        vecs[11] = '{1'b0, 3'b111, 3'b001, 1'b1, 3'b110, 1'b0};
        vecs[12] = '{1'b0, 3'b111, 3'b100, 1'b1, 3'b010, 1'b0};
        vecs[13] = '{1'b0, 3'b111, 3'b010, 1'b0, 3'b010, 1'b0};
        vecs[14] = '{1'b0, 3'b111, 3'b011, 1'b1, 3'b000, 1'b0};
        vecs[15] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0};
        for (int k = 0; k < 16; k++) begin
            reset_r  = vecs[k].rst;
            button_r = vecs[k].btn;
            floor_r  = vecs[k].flr;
            door_r   = vecs[k].dr;
            tick();
            check($sformatf("vec%0d", k), vecs[k].exp_req, vecs[k].exp_new);
        end

        // Bounce on button[1]: only the final stable level counts.
        do_reset();
        pat = '{1, 0, 1, 0, 1};
        for (int j = 0; j < 5; j++) begin
            button_r[1] = pat[j][0];
            tick();
            check("bounce_quiet", 3'b000, 1'b0);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("bounce_k%0d", k), (k >= 2 + DB) ? 3'b010 : 3'b000, k == 2 + DB);
        end

        // Press completes while the car sits at that floor with the door open.
        do_reset();
        floor_r  = 3'b010;
        door_r   = 1'b1;
        button_r = 3'b010;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("served_press", 3'b000, 1'b0);
        end
        door_r = 1'b0;
        repeat (3) begin
            tick();
            check("served_after", 3'b000, 1'b0);
        end

        // Re-press while pending, then service and a fresh press.
        do_reset();
        button_r = 3'b100;
        for (int k = 0; k <= 2 + DB; k++) begin
            tick();
            check("repress_first", (k >= 2 + DB) ? 3'b100 : 3'b000, k == 2 + DB);
        end
        button_r = 3'b000;
        repeat (8) begin
            tick();
            check("repress_rel1", 3'b100, 1'b0);
        end
        button_r = 3'b100;
        repeat (10) begin
            tick();
            check("repress_again", 3'b100, 1'b0);
        end
        button_r = 3'b000;
        repeat (8) tick();
        floor_r = 3'b100;
        door_r  = 1'b1;
        tick();
        check("repress_service", 3'b000, 1'b0);
        floor_r = 3'b000;
        door_r  = 1'b0;
        button_r = 3'b100;
        for (int k = 0; k <= 2 + DB; k++) begin
            tick();
            check("repress_fresh", (k >= 2 + DB) ? 3'b100 : 3'b000, k == 2 + DB);
        end
        button_r = 3'b000;

        // Long hold on button[0].
        do_reset();
        button_r = 3'b001;
        for (int k = 0; k <= 2 + DB + LP + 4; k++) begin
            tick();
            if (k < 2 + DB) er = 3'b000;
`ifdef CALL_CANCEL_EN
            else if (k >= 2 + DB + LP) er = 3'b000;
`endif
            else er = 3'b001;
            check($sformatf("long_k%0d", k), er, k == 2 + DB);
        end
        button_r = 3'b000;

        // Random stimulus against the reference model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 7) == 0) button_r[i] = ~button_r[i];
            end
            floor_r = 3'($urandom_range(0, 7));
            door_r  = ($urandom_range(0, 4) == 0);
            reset_r = ($urandom_range(0, 499) == 0);
            tick();
            check($sformatf("rand%0d", n), m_req, m_new);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
